// File: rtl/burst_gen_pkg.sv
// Shared types and constants for burst_gen.
package burst_gen_pkg;

  // RUN presents beats; DONE is the one-cycle completion pulse before IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } burst_state_t;

  // Width of the dropped-trigger counter; it saturates at 2^OVR_CNT_W - 1.
  localparam int OVR_CNT_W = 8;

endpackage

// File: rtl/burst_gen.sv
// burst_gen: turns each accepted trigger pulse into a burst of burst_len beats
// (seed, seed+1, ...) on a valid/ready stream. It reports busy/done status and
// a sticky overrun flag for dropped triggers.
// Optional build macro BURST_GEN_OVERRUN_CNT_EN adds the saturating
// overrun_cnt output.
module burst_gen
  import burst_gen_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  input  logic              overrun_clr
`ifdef BURST_GEN_OVERRUN_CNT_EN
  ,output logic [OVR_CNT_W-1:0] overrun_cnt
`endif
);

  burst_state_t      state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              overrun_q, overrun_d;
  logic              drop;
  logic              is_last;

  assign is_last = (idx_q == len_q - LEN_W'(1));

  // Next-state logic. Triggers arriving while busy are dropped, and that
  // includes the cycle of the final handshake.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    val_d   = val_q;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && (burst_len != '0)) begin
          len_d   = burst_len;
          val_d   = seed;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        drop = enable;
        if (m_ready) begin
          val_d = val_q + DATA_W'(1);
          idx_d = idx_q + LEN_W'(1);
          if (is_last) state_d = DONE;
        end
      end
      DONE: begin
        drop    = enable;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // When a drop and a clear land in the same cycle, the drop wins.
    overrun_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      val_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      val_q     <= val_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs are decoded from state. Data is zeroed outside RUN so that it
  // does not leak the stale value.
  always_comb begin
    m_valid = (state_q == RUN);
    m_data  = m_valid ? val_q : '0;
    m_last  = m_valid && is_last;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    overrun = overrun_q;
  end

`ifdef BURST_GEN_OVERRUN_CNT_EN
  logic [OVR_CNT_W-1:0] cnt_q, cnt_d;

  // Saturating drop counter. A clear in the same cycle as a drop leaves 1.
  always_comb begin
    cnt_d = cnt_q;
    if (drop) begin
      if (overrun_clr)      cnt_d = OVR_CNT_W'(1);
      else if (~&cnt_q)     cnt_d = cnt_q + OVR_CNT_W'(1);
    end else if (overrun_clr) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign overrun_cnt = cnt_q;
`endif

endmodule

// File: doc/burst_gen.md
# burst_gen

Downstream consumer of the one-cycle `enable` trigger pulse. Each accepted trigger produces one burst of `burst_len` data beats on a valid/ready stream. Beat values are `seed + index`. The block sits between the trigger repeater and the sample/DMA stream path. It reports busy/done status and flags triggers it had to drop.

## Interface
Parameters:
- `DATA_W`, 16, stream data width
- `LEN_W`, 10, width of burst length and beat index (max burst 2^LEN_W − 1)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `enable`  in  1  trigger pulse (one cycle wide from upstream)
- `burst_len`  in  LEN_W  beats per burst, sampled on accepted trigger
- `seed`  in  DATA_W  first beat value, sampled on accepted trigger
- `m_data`  out  DATA_W  beat payload
- `m_valid`  out  1  beat valid
- `m_ready`  in  1  downstream accept
- `m_last`  out  1  final beat of burst (qualified by `m_valid`)
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse after final beat accepted
- `overrun`  out  1  sticky: a trigger was dropped
- `overrun_clr`  in  1  clears `overrun` (and counter if compiled)
- `overrun_cnt`  out  8  dropped-trigger count (only with macro, see Configuration)

## Operation
- Reset (async assert, sync release): state IDLE; all outputs 0, `m_data` = 0; internal index/length/value registers 0.
- FSM states:
  - IDLE
    - `enable` & `burst_len` != 0 → latch `burst_len` into `len_q`, `seed` into `val_q`, index = 0 → RUN.
    - `enable` & `burst_len` == 0 → ignored, stay IDLE, no overrun.
  - RUN
    - `m_valid` = 1, `m_data` = `val_q`, `m_last` = (index == `len_q` − 1).
    - On `m_valid & m_ready`: `val_q` += 1 (wraps mod 2^DATA_W), index += 1.
    - Handshake on the last beat → DONE.
  - DONE: `done` = 1 for exactly this cycle → IDLE.
- Stall: while `m_ready` = 0 in RUN, `m_data`/`m_last`/`m_valid` hold; no beat dropped or duplicated.
- Triggers in RUN or DONE (including the cycle of the final handshake) are dropped. They set `overrun`. `burst_len`/`seed` are not resampled.
- `overrun_clr` and a new drop in the same cycle: drop wins (`overrun` stays 1, count = 1).
- `m_valid` never deasserts mid-burst without a handshake.

## Timing
- Trigger at edge t (IDLE) → `m_valid` = 1 from t+1. The first beat can be accepted at t+1.
- With `m_ready` held high, beats are accepted every cycle. The final beat is at t+`burst_len`; `done` is high in cycle t+`burst_len`+1.
- The next trigger is accepted no earlier than cycle t+`burst_len`+2 (IDLE).
- `busy` rises at t+1 and falls after the DONE cycle.
- Async `reset` mid-burst: outputs go to 0 immediately (no `done`). The interrupted burst is abandoned.

## Configuration
- `BURST_GEN_OVERRUN_CNT_EN` defined:
  - `overrun_cnt` port exists.
  - It increments on each dropped trigger and saturates at 255.
  - It clears on `overrun_clr` (drop in same cycle → 1).
- Undefined:
  - Port and counter are absent.
  - Only the sticky `overrun` flag is provided; all other behaviour is identical.

## Structure
- Package `burst_gen_pkg`: FSM state enum `burst_state_t` {IDLE, RUN, DONE}, localparam `OVR_CNT_W` = 8.
- No sub-module needed. Optional `sat_counter` sub-module (width param, inc/clr, saturating) for the overrun counter, reusable elsewhere.
- Single always_ff for FSM/datapath; combinational output decode from state.

## Test plan
- Reset: assert `reset` mid-burst (`burst_len` = 8, after 3 beats) → `m_valid`/`busy`/`done` = 0 immediately, no further beats. Then trigger again → full 8-beat burst from the new seed.
- Basic burst: `burst_len` = 4, `seed` = 16'h00FE, `m_ready` = 1, trigger at t → beats 00FE, 00FF, 0100, 0101 at t+1..t+4; `m_last` only on 0101; `done` at t+5.
- Backpressure: `burst_len` = 3, `m_ready` toggles 1,0,0,1,0,1 → exactly 3 beats accepted in order. Data is held stable across every stalled cycle.
- Wrap: `DATA_W` = 16, `seed` = 16'hFFFF, `burst_len` = 2 → beats FFFF, 0000.
- Overrun: trigger during RUN, in DONE, and on the final-beat cycle → burst unaffected; `overrun` = 1; `overrun_cnt` = 3 (with macro). `overrun_clr` → 0. 300 drops → `overrun_cnt` = 255.
- Zero length: `burst_len` = 0 trigger in IDLE → no `m_valid`, no `busy`, no `done`, `overrun` stays 0.
